uart_rx_ovs: RTL and testbench
==============================

# uart_rx_ovs

Parametrised oversampling UART receiver, next generation of the fixed 8N1 receiver. Used as the serial-input block wherever the UART transmitter's output, or an external pin, is received. Adds configurable data width, stop-bit count, optional parity, 3-sample majority voting, false-start rejection, and framing/parity/break reporting. One `o_rx_dv` pulse is produced per completed frame.

## Interface
- `CLOCK_FREQUENCY`, default 100_000_000: clock frequency in Hz.
- `BAUD_RATE`, default 9600: line rate in bit/s.
- `OVERSAMPLE`, default 16: samples per bit. Even, ≥8.
- `DATA_BITS`, default 8: payload width, 5..9.
- `STOP_BITS`, default 1: 1 or 2.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd. Only used when parity is compiled in.
- `i_clk` in 1: system clock.
- `i_rstn` in 1: reset, asynchronous, active-low.
- `i_rx_serial` in 1: asynchronous serial line, idle high.
- `o_rx_dv` out 1: one-cycle pulse; a frame has completed.
- `o_rx_byte` out DATA_BITS: received payload, LSB first on the line. Held until the next `o_rx_dv`.
- `o_frame_err` out 1: a stop bit was sampled low. Valid with `o_rx_dv`.
- `o_parity_err` out 1: parity mismatch. Valid with `o_rx_dv`.
- `o_break` out 1: all data bits and the stop bit were low. Valid with `o_rx_dv`.
- `o_rx_busy` out 1: high in every state except IDLE.

## Operation
- Input synchroniser: two flops, reset value 1. All logic uses the synchronised line `rx_s`.
- Tick divider: `TICK_DIV = CLOCK_FREQUENCY/(BAUD_RATE*OVERSAMPLE)`, integer truncation (651 at the defaults). Free-running counter 0..TICK_DIV-1 with reset value 0. `tick` pulses on the cycle where the counter equals TICK_DIV-1.
- Sample counter `s` runs 0..OVERSAMPLE-1, advancing on `tick`. Each bit is the majority of samples at s = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
- **IDLE:** when `rx_s`==0, clear `s` and go to START.
- **START:** evaluate the majority at s = OVERSAMPLE/2+1.
  - Majority 1 (false start): return to IDLE. No `o_rx_dv`.
  - Majority 0: continue to s = OVERSAMPLE-1, then go to DATA.
- **DATA:** shift in DATA_BITS majority-voted bits, LSB first. Then go to PARITY if compiled in, otherwise STOP.
- **PARITY:** sample one bit.
  - `parity_err` = XOR(data bits, parity bit) XOR PARITY_ODD, which is nonzero on a mismatch.
- **STOP:** sample STOP_BITS bits. Any low stop bit sets `frame_err`.
  - At the majority point of the last stop bit, load the outputs and pulse `o_rx_dv`.
  - If `frame_err`==0, go to IDLE. This allows back-to-back frames, since the next start edge is accepted from the middle of the stop bit onward.
  - If `frame_err`==1, go to WAIT_IDLE.
- **WAIT_IDLE:** stay until `rx_s`==1, then go to IDLE. A held-low line therefore yields exactly one `o_rx_dv`.
- `o_break` = `frame_err` AND (all data bits 0) AND (parity bit 0 when parity is compiled in).

## Timing
- Reset values: all outputs are 0, `o_rx_byte` = 0, the state is IDLE, and both synchroniser flops are 1.
- Reset takes effect immediately, including mid-frame. Asserting reset mid-frame must not produce an `o_rx_dv` pulse or any partial update of `o_rx_byte`.
- Start detection latency is 2 `i_clk` cycles (synchroniser) plus 1 cycle for the IDLE→START transition.
- `o_rx_dv` is registered. It is high for exactly one cycle: the cycle after the `tick` that takes sample OVERSAMPLE/2+1 of the last stop bit.
- `o_rx_byte` and the error flags update on that same cycle.
- Nominal bit period is TICK_DIV·OVERSAMPLE clocks, i.e. 10416 clocks at the defaults. The receiver must tolerate ±2% baud mismatch.
- A single-sample glitch inside a bit must not change the voted value.

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: the PARITY state is present and `o_parity_err` is computed as described above.
  - Undefined: no PARITY state, `o_parity_err` is tied to 0, and `PARITY_ODD` is ignored. The frame is then start + DATA_BITS + STOP_BITS.

## Test plan
All scenarios use the default parameters and drive `i_rx_serial` with a 104160 ns bit period.
- **Basic frame:** frame 0xA1, macro off → exactly one `o_rx_dv`; `o_rx_byte`=0xA1; `o_frame_err`, `o_parity_err` and `o_break` all 0.
- **Parity mismatch:** macro on, even parity, 0xA1 sent with parity bit 0 → `o_rx_byte`=0xA1, `o_parity_err`=1. Same frame with parity bit 1 → `o_parity_err`=0.
- **Glitch rejection:**
  - 3000 ns low pulse on an idle line → no `o_rx_dv`; `o_rx_busy` returns to 0 within 1 bit time.
  - One-tick (6510 ns) inverted glitch at the start of bit 2 of frame 0x55 → `o_rx_byte`=0x55.
- **Framing error and break:**
  - 0x55 with stop bit 0 → `o_frame_err`=1, `o_break`=0.
  - Line held low for 12 bit times → one `o_rx_dv` with `o_rx_byte`=0x00, `o_frame_err`=1, `o_break`=1. No further pulse until the line returns high and a new frame 0x3C is received correctly.
- **Back-to-back:** frames 0x00, 0xFF, 0x5A sent with no idle gap, STOP_BITS=2 → three `o_rx_dv` pulses carrying those values in order, all error flags 0.
- **Reset mid-frame:** `i_rstn` low during data bit 3 → all outputs 0 immediately and no `o_rx_dv`. After release and 1 idle bit, frame 0x3C → `o_rx_byte`=0x3C.

Source files
------------

// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs: oversampling UART receiver with 3-sample majority voting and framing/parity/break flags.
// Define UART_RX_PARITY_EN to add the parity bit between data and stop bits.
module uart_rx_ovs #(
  parameter int CLOCK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE       = 9600,
  parameter int OVERSAMPLE      = 16,
  parameter int DATA_BITS       = 8,
  parameter int STOP_BITS       = 1,
  parameter int PARITY_ODD      = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_rx_serial,
  output logic                 o_rx_dv,
  output logic [DATA_BITS-1:0] o_rx_byte,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_break,
  output logic                 o_rx_busy
);
  localparam int TICK_DIV = CLOCK_FREQUENCY / (BAUD_RATE * OVERSAMPLE);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam int MID = OVERSAMPLE / 2;
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
  localparam state_t AFTER_DATA = PARITY;
  localparam bit PAR_EN = 1'b1;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
  localparam state_t AFTER_DATA = STOP;
  localparam bit PAR_EN = 1'b0;
`endif
  state_t state, state_n;
  logic rx_m, rx_s;
  logic [CW-1:0] cnt;
  logic [SW-1:0] s;
  logic [BW-1:0] bcnt;
  logic [DATA_BITS-1:0] data;
  logic v0, v1, vote, ferr, pbit, fe_n;
  logic tick, at_mid, at_end, last_data, last_stop, done;
  assign tick      = cnt == CW'(TICK_DIV - 1);
  assign at_mid    = tick && s == SW'(MID + 1);
  assign at_end    = tick && s == SW'(OVERSAMPLE - 1);
  assign vote      = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);
  assign last_data = bcnt == BW'(DATA_BITS - 1);
  assign last_stop = bcnt == BW'(STOP_BITS - 1);
  assign fe_n      = ferr | ~vote;
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) {rx_m, rx_s} <= 2'b11;
    else {rx_m, rx_s} <= {i_rx_serial, rx_m};
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = rx_s ? IDLE : START;
      START:     state_n = at_mid && vote ? IDLE : at_end ? DATA : START;
      DATA:      state_n = at_end && last_data ? AFTER_DATA : DATA;
`ifdef UART_RX_PARITY_EN
      PARITY:    state_n = at_end ? STOP : PARITY;
`endif
      STOP:      state_n = at_mid && last_stop ? (fe_n ? WAIT_IDLE : IDLE) : STOP;
      WAIT_IDLE: state_n = rx_s ? IDLE : WAIT_IDLE;
      default:   state_n = IDLE;
    endcase
  end
  always_comb begin
    o_rx_busy = state != IDLE;
    done      = state == STOP && at_mid && last_stop;
  end
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      s            <= '0;
      bcnt         <= '0;
      v0           <= 1'b1;
      v1           <= 1'b1;
      data         <= '0;
      ferr         <= 1'b0;
      o_rx_dv      <= 1'b0;
      o_rx_byte    <= '0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
      o_break      <= 1'b0;
    end else begin
      o_rx_dv <= done;
      if (state == IDLE) begin
        s    <= '0;
        bcnt <= '0;
        ferr <= 1'b0;
      end else if (tick) s <= s == SW'(OVERSAMPLE - 1) ? '0 : s + 1'b1;
      if (tick && s == SW'(MID - 1)) v0 <= rx_s;
      if (tick && s == SW'(MID)) v1 <= rx_s;
      if (state == DATA && at_mid) data <= {vote, data[DATA_BITS-1:1]};
      if (at_end && (state == DATA || state == STOP)) bcnt <= state == DATA && last_data ? '0 : bcnt + 1'b1;
      if (state == STOP && at_mid) ferr <= fe_n;
      if (done) begin
        o_rx_byte    <= data;
        o_frame_err  <= fe_n;
        o_parity_err <= PAR_EN & (^data ^ pbit ^ (PARITY_ODD != 0));
        o_break      <= fe_n && data == '0 && !pbit;
      end
    end
`ifdef UART_RX_PARITY_EN
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) pbit <= 1'b0;
    else if (state == PARITY && at_mid) pbit <= vote;
`else
  assign pbit = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_ovs.sv
// tb_uart_rx_ovs: directed and randomized frames checked against a frame-level reference model.
// The clock is scaled so one bit is 64 clocks (4-clock tick) to keep the run short.
module tb_uart_rx_ovs;
  localparam int CF = 614_400, BR = 9600, OVS = 16, DB = 8, SB = 2, ODD = 0;
  localparam int TK = CF / (BR * OVS);
  localparam int BIT = TK * OVS;
`ifdef UART_RX_PARITY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif
  typedef struct packed {logic [DB-1:0] b; logic f, p, k;} rec_t;
  logic clk = 1'b0, rstn = 1'b0, rx = 1'b1;
  logic dv, ferr, perr, brk, busy;
  logic [DB-1:0] byt;
  rec_t got_q[$], exp_q[$];
  int total = 0, bad = 0;

  uart_rx_ovs #(.CLOCK_FREQUENCY(CF), .BAUD_RATE(BR), .OVERSAMPLE(OVS), .DATA_BITS(DB),
                .STOP_BITS(SB), .PARITY_ODD(ODD)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_rx_serial(rx), .o_rx_dv(dv), .o_rx_byte(byt),
    .o_frame_err(ferr), .o_parity_err(perr), .o_break(brk), .o_rx_busy(busy));

  always #5 clk = ~clk;
  always @(negedge clk) if (dv) got_q.push_back({byt, ferr, perr, brk});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic good_par(input logic [DB-1:0] d);
    return 1'(($countones(d) + ODD) % 2);
  endfunction

  function automatic rec_t model(input logic [DB-1:0] d, input logic pb, input logic [SB-1:0] stp);
    rec_t r;
    r.b = d;
    r.f = stp != '1;
    r.p = PEN && (($countones(d) + pb + ODD) % 2 == 1);
    r.k = r.f && d == 0 && !(PEN && pb);
    return r;
  endfunction

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
  endtask

  task automatic send(input logic [DB-1:0] d, input logic pb, input logic [SB-1:0] stp,
                      input int per, input int gl, input int go, input int gw);
    drive(1'b0, per);
    for (int i = 0; i < DB; i++)
      if (i == gl) begin
        drive(d[i], go);
        drive(!d[i], gw);
        drive(d[i], per - go - gw);
      end else drive(d[i], per);
    if (PEN) drive(pb, per);
    for (int i = 0; i < SB; i++) drive(stp[i], per);
    rx = 1'b1;
    exp_q.push_back(model(d, pb, stp));
  endtask

  task automatic check_frames(input string tag);
    @(negedge clk);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({tag, "_frame"}, 32'(got_q[i]), 32'(exp_q[i]));
    if (exp_q.size() > 0) chk({tag, "_held"}, 32'(byt), 32'(exp_q[$].b));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [DB-1:0] d;
    logic [SB-1:0] stp;
    int w;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_dv", 32'(dv), 0);
    chk("reset_outs", 32'({byt, ferr, perr, brk}), 0);
    chk("reset_busy", 32'(busy), 0);
    rstn = 1'b1;
    drive(1'b1, 2 * BIT);
    send(8'hA1, 1'b0, '1, BIT, -1, 0, 0);
    drive(1'b1, BIT);
    check_frames("a1_pbit0");
    send(8'hA1, 1'b1, '1, BIT, -1, 0, 0);
    drive(1'b1, BIT);
    check_frames("a1_pbit1");
    drive(1'b0, 10);
    @(negedge clk);
    chk("false_start_busy_hi", 32'(busy), 1);
    drive(1'b0, 10);
    rx = 1'b1;
    w = 0;
    while (busy && w < BIT) begin
      @(negedge clk);
      w++;
    end
    chk("false_start_busy_lo", 32'(busy), 0);
    drive(1'b1, 2 * BIT);
    check_frames("false_start");
    send(8'h55, good_par(8'h55), '1, BIT, 2, 0, TK);
    drive(1'b1, BIT);
    check_frames("glitch_bit2");
    send(8'h55, good_par(8'h55), '0, BIT, -1, 0, 0);
    drive(1'b1, BIT);
    check_frames("frame_err");
    drive(1'b0, 12 * BIT);
    exp_q.push_back(model('0, 1'b0, '0));
    drive(1'b1, 2 * BIT);
    check_frames("hold_low");
    send(8'h3C, good_par(8'h3C), '1, BIT, -1, 0, 0);
    drive(1'b1, BIT);
    check_frames("after_break");
    send(8'h00, good_par(8'h00), '1, BIT, -1, 0, 0);
    send(8'hFF, good_par(8'hFF), '1, BIT, -1, 0, 0);
    send(8'h5A, good_par(8'h5A), '1, BIT, -1, 0, 0);
    drive(1'b1, BIT);
    check_frames("back2back");
    d = 8'h3C;
    drive(1'b0, BIT);
    for (int i = 0; i < 3; i++) drive(d[i], BIT);
    drive(d[3], BIT / 2);
    rstn = 1'b0;
    #1;
    chk("midreset_outs", 32'({dv, byt, ferr, perr, brk, busy}), 0);
    drive(1'b1, 4 * BIT);
    rstn = 1'b1;
    drive(1'b1, BIT);
    send(8'h3C, good_par(8'h3C), '1, BIT, -1, 0, 0);
    drive(1'b1, BIT);
    check_frames("midreset_next");
    for (int n = 0; n < 30; n++) begin
      d = DB'($urandom);
      stp = $urandom_range(0, 4) == 0 ? SB'($urandom) : '1;
      if ($urandom_range(0, 1) == 1)
        send(d, good_par(d) ^ ($urandom_range(0, 3) == 0), stp, BIT - 1 + $urandom_range(0, 2),
             $urandom_range(0, DB), $urandom_range(28, 44), 3);
      else
        send(d, good_par(d) ^ ($urandom_range(0, 3) == 0), stp, BIT - 1 + $urandom_range(0, 2),
             $urandom_range(0, DB), 0, TK);
      drive(1'b1, stp[SB-1] ? $urandom_range(0, 20) : $urandom_range(4, 20));
      check_frames("random");
    end
    drive(1'b1, BIT);
    check_frames("final_idle");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
